// File: rtl/grayscale_to_rgb565_pkg.sv
// Shared types and RGB565 field layout for the grayscale-to-RGB565 expander.
package grayscale_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HALF_A = 2'd1,
      HALF_B = 2'd2
   } state_e;

   localparam int GRAY_W = 8;
   localparam int PIX_W  = 16;

   localparam int R_W   = 5;
   localparam int G_W   = 6;
   localparam int B_W   = 5;
   localparam int R_OFF = 11;
   localparam int G_OFF = 5;
   localparam int B_OFF = 0;

endpackage

// File: rtl/grayscale_to_rgb565_if.sv
// Stream bundle: 4-pixel gray words in, 2-pixel RGB565 words out, with frame-last flag.
interface grayscale_to_rgb565_if;
   logic        inValid;
   logic        inReady;
   logic [31:0] inData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic        outLast;

   modport slave (
      input  inValid, inData, outReady,
      output inReady, outValid, outData, outLast
   );

   modport master (
      output inValid, inData, outReady,
      input  inReady, outValid, outData, outLast
   );
endinterface

// File: rtl/grayscale_to_rgb565_expand.sv
// Single-pixel gray8 -> RGB565 replication, purely combinational.
module gray8ToRgb565
   import grayscale_pkg::*;
(
   input  logic [GRAY_W-1:0] gray,
   output logic [PIX_W-1:0]  rgb
);
   logic unused_lsbs;

   // Truncate to each channel's width; the two lowest gray bits never reach any channel.
   assign rgb[R_OFF +: R_W] = gray[GRAY_W-1 -: R_W];
   assign rgb[G_OFF +: G_W] = gray[GRAY_W-1 -: G_W];
   assign rgb[B_OFF +: B_W] = gray[GRAY_W-1 -: B_W];

   assign unused_lsbs = ^gray[1:0];
endmodule

// File: rtl/grayscale_to_rgb565.sv
// Splits each 4-pixel gray word into two registered RGB565 words; first word valid after the accept edge.
// Holds outputs stable under outReady=0; accepts a new word only when empty or when the last half leaves.
module grayscale_to_rgb565
   import grayscale_pkg::*;
#(
   parameter int FRAME_PIXELS = 307200
)(
   input  logic                  clock,
   input  logic                  nReset,
   input  logic                  clear,
   grayscale_to_rgb565_if.slave  bus
);
   localparam int WORDS_PER_FRAME = FRAME_PIXELS / 2;
   localparam int CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_FRAME - 1);

   state_e            state_q, state_d;
   logic [15:0]       hold_q, hold_d;
   logic [31:0]       out_dat_q, out_dat_d;
   logic              out_vld_q, out_vld_d;
   logic              out_last_q, out_last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              in_hs, out_hs, in_rdy;
   logic              sel_new, load_dat;
   logic [15:0]       src_pair;
   logic [PIX_W-1:0]  pix_lo, pix_hi;

   assign in_rdy = !clear && ((state_q == EMPTY) || ((state_q == HALF_B) && bus.outReady));
   assign in_hs  = bus.inValid && in_rdy;
   assign out_hs = out_vld_q && bus.outReady && !clear;

   // A fresh word supplies p0,p1 directly; otherwise the held p2,p3 feed the expanders.
   assign src_pair = sel_new ? bus.inData[15:0] : hold_q;

   gray8ToRgb565 u_exp_lo (.gray(src_pair[7:0]),  .rgb(pix_lo));
   gray8ToRgb565 u_exp_hi (.gray(src_pair[15:8]), .rgb(pix_hi));

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      sel_new  = 1'b0;
      load_dat = 1'b0;

      if (clear) begin
         state_d = EMPTY;
         cnt_d   = '0;
      end else begin
         if (out_hs) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
         end
         unique case (state_q)
            EMPTY: begin
               if (in_hs) begin
                  sel_new  = 1'b1;
                  load_dat = 1'b1;
                  hold_d   = bus.inData[31:16];
                  state_d  = HALF_A;
               end
            end
            HALF_A: begin
               if (out_hs) begin
                  load_dat = 1'b1;
                  state_d  = HALF_B;
               end
            end
            HALF_B: begin
               if (out_hs && in_hs) begin
                  sel_new  = 1'b1;
                  load_dat = 1'b1;
                  hold_d   = bus.inData[31:16];
                  state_d  = HALF_A;
               end else if (out_hs) begin
                  state_d  = EMPTY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      out_dat_d  = load_dat ? {pix_hi, pix_lo} : out_dat_q;
      out_vld_d  = (state_d != EMPTY);
      out_last_d = out_vld_d && (cnt_d == LAST_IDX);
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q    <= EMPTY;
         hold_q     <= '0;
         out_dat_q  <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         out_dat_q  <= out_dat_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.inReady  = in_rdy;
   assign bus.outValid = out_vld_q;
   assign bus.outData  = out_dat_q;
   assign bus.outLast  = out_last_q;
endmodule

// File: tb/tb_grayscale_to_rgb565.sv
// Self-checking bench for grayscale_to_rgb565 with a queue-based reference model (8-pixel frames).
module tb_grayscale_to_rgb565;
   localparam int FP  = 8;
   localparam int WPF = FP / 2;

   logic clock;
   logic nReset;
   logic clear;

   grayscale_to_rgb565_if bus();

   grayscale_to_rgb565 #(.FRAME_PIXELS(FP)) dut (
      .clock  (clock),
      .nReset (nReset),
      .clear  (clear),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   logic [31:0] q[$];
   int          mcnt     = 0;
   int          hs_count = 0;
   int          last_log[$];
   bit          tab_mode = 1'b0;
   logic [31:0] tab_w0, tab_w1;

   typedef struct {
      logic [31:0] din;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   function automatic logic [15:0] px(input logic [7:0] g);
      int r5, g6;
      r5 = int'(g) / 8;
      g6 = int'(g) / 4;
      return 16'(r5 * 2048 + g6 * 32 + r5);
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock period: drive at the falling edge, check against the model, advance the model.
   task automatic cycle(input bit iv, input logic [31:0] id, input bit ordy, input bit clr,
                        output bit acc);
      bit exp_rdy;
      bus.inValid  = iv;
      bus.inData   = id;
      bus.outReady = ordy;
      clear        = clr;
      #1;
      exp_rdy = !clr && (q.size() == 0 || (q.size() == 1 && ordy));
      check_bit("in_ready", bus.inReady, exp_rdy);
      check_bit("out_valid", bus.outValid, q.size() != 0);
      if (q.size() != 0) begin
         check_word("out_data", bus.outData, q[0]);
         check_bit("out_last", bus.outLast, mcnt == WPF - 1);
      end
      acc = 1'b0;
      if (clr) begin
         q.delete();
         mcnt = 0;
      end else begin
         if (q.size() != 0 && ordy) begin
            void'(q.pop_front());
            if (bus.outLast) last_log.push_back(hs_count);
            hs_count++;
            mcnt = (mcnt + 1) % WPF;
         end
         if (iv && exp_rdy) begin
            acc = 1'b1;
            if (tab_mode) begin
               q.push_back(tab_w0);
               q.push_back(tab_w1);
            end else begin
               q.push_back({px(id[15:8]), px(id[7:0])});
               q.push_back({px(id[31:24]), px(id[23:16])});
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic drain(input int budget);
      bit acc;
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
         n++;
      end
      check_int("drain_left", q.size(), 0);
   endtask

   task automatic stream4();
      int idx = 0;
      int cyc = 0;
      int base;
      bit acc;
      logic [31:0] w;
      base = hs_count;
      last_log.delete();
      w = $urandom;
      while ((idx < 4 || q.size() != 0) && cyc < 24) begin
         cycle(idx < 4, w, 1'b1, 1'b0, acc);
         if (acc) begin
            idx++;
            w = $urandom;
         end
         cyc++;
      end
      check_int("stream_cycles", cyc, 9);
      check_int("stream_words", hs_count - base, 8);
      check_int("stream_last_cnt", last_log.size(), 2);
      for (int k = 0; k < 2 && k < last_log.size(); k++)
         check_int("stream_last_pos", last_log[k] - base, 4 * k + 3);
   endtask

   vec_t vecs[5];
   bit   acc;
   int   n;
   int   hs0;

   initial begin
      vecs[0] = '{32'h4080FF00, 32'hFFFF0000, 32'h42088410};
      vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3] = '{32'h12345678, 32'h52AA7BCF, 32'h108231A6};
      vecs[4] = '{32'h08040201, 32'h00000000, 32'h08410020};

      nReset       = 1'b0;
      clear        = 1'b0;
      bus.inValid  = 1'b0;
      bus.inData   = '0;
      bus.outReady = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      check_bit("rst_out_valid", bus.outValid, 1'b0);
      check_word("rst_out_data", bus.outData, 32'h0);
      check_bit("rst_out_last", bus.outLast, 1'b0);
      nReset = 1'b1;
      #1;
      check_bit("rst_in_ready", bus.inReady, 1'b1);
      @(negedge clock);

      // Table vectors with hand-computed expected words
      tab_mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tab_w0 = vecs[i].w0;
         tab_w1 = vecs[i].w1;
         acc = 1'b0;
         n = 0;
         while (!acc && n < 4) begin
            cycle(1'b1, vecs[i].din, 1'b1, 1'b0, acc);
            n++;
         end
         check_bit("vec_accept", acc, 1'b1);
         drain(4);
      end
      tab_mode = 1'b0;

      // Backpressure: first word held five cycles, then both words exactly once
      hs0 = hs_count;
      cycle(1'b1, 32'h4080FF00, 1'b0, 1'b0, acc);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'h11223344, 1'b0, 1'b0, acc);
         check_word("bp_hold", bus.outData, 32'hFFFF0000);
      end
      drain(4);
      check_int("bp_words", hs_count - hs0, 2);

      // Streaming frame after a clear
      cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
      stream4();

      // Clear while HALF_A with a pending input word
      cycle(1'b1, 32'hA5A55A5A, 1'b1, 1'b0, acc);
      hs0 = hs_count;
      cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, acc);
      check_bit("clr_no_accept", acc, 1'b0);
      check_int("clr_no_out_hs", hs_count - hs0, 0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
      stream4();

      // Asynchronous reset while in HALF_B mid-frame
      cycle(1'b1, $urandom, 1'b1, 1'b0, acc);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
      bus.outReady = 1'b0;
      bus.inValid  = 1'b0;
      #2;
      nReset = 1'b0;
      #1;
      check_bit("arst_out_valid", bus.outValid, 1'b0);
      check_word("arst_out_data", bus.outData, 32'h0);
      check_bit("arst_out_last", bus.outLast, 1'b0);
      q.delete();
      mcnt = 0;
      @(negedge clock);
      nReset = 1'b1;
      stream4();

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 63) == 0, acc);
      end
      drain(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
